// File: rtl/dcache_port_arbiter.sv
// Arbitrates the pipeline load/store port and the CACOP port onto one dcache
// request channel, with a starvation counter so CACOP cannot be locked out.
module dcache_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        flush,
    input  logic        p_valid,
    input  logic        p_op,
    input  logic [3:0]  p_wstrb,
    input  logic [31:0] p_addr,
    input  logic [31:0] p_wdata,
    input  logic        p_atom,
    output logic        p_ready,
    output logic        p_done,
    output logic [31:0] p_rdata,
    input  logic        c_valid,
    input  logic [1:0]  c_type,
    input  logic [31:0] c_addr,
    output logic        c_ready,
    output logic        c_done,
    output logic        dc_rvalid,
    output logic        dc_wvalid,
    output logic        dc_op,
    output logic [3:0]  dc_wstrb,
    output logic [31:0] dc_addr,
    output logic [31:0] dc_wdata,
    output logic        dc_atom,
    output logic        dc_cacop_en,
    output logic [1:0]  dc_cacop_type,
    input  logic        dc_rready,
    input  logic        dc_wready,
    input  logic        dc_cacop_done,
    input  logic [31:0] dc_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state;
    state_t      state_nx;
    logic        own_c;
    logic        h_op;
    logic        h_atom;
    logic [3:0]  h_wstrb;
    logic [31:0] h_addr;
    logic [31:0] h_wdata;
    logic [1:0]  h_ctype;
    logic [31:0] rdata_q;
    logic [3:0]  starve;
    logic        squash;
    logic        p_req;
    logic        p_win;
    logic        c_win;
    logic        cmpl;
    logic        in_busy;

    always_comb begin
        state_nx = state;
        p_req    = aresetn && p_valid && !flush;
        p_win    = 1'b0;
        c_win    = 1'b0;
        cmpl     = 1'b0;
        unique case (state)
            IDLE: begin
                c_win = aresetn && c_valid && (!p_req || starve == LIMIT);
                p_win = p_req && !c_win;
                if (p_win || c_win)
                    state_nx = BUSY;
            end
            BUSY: begin
                // Only the owner's completion strobe counts.
                cmpl = own_c ? dc_cacop_done : (h_op ? dc_wready : dc_rready);
                if (cmpl)
                    state_nx = DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state   <= IDLE;
            own_c   <= 1'b0;
            h_op    <= 1'b0;
            h_atom  <= 1'b0;
            h_wstrb <= 4'b0;
            h_addr  <= 32'b0;
            h_wdata <= 32'b0;
            h_ctype <= 2'b0;
            rdata_q <= 32'b0;
            starve  <= 4'b0;
            squash  <= 1'b0;
        end else begin
            state <= state_nx;
            if (p_win) begin
                own_c   <= 1'b0;
                h_op    <= p_op;
                h_atom  <= p_atom;
                h_wstrb <= p_op ? p_wstrb : 4'b0;
                h_addr  <= p_addr;
                h_wdata <= p_op ? p_wdata : 32'b0;
                h_ctype <= 2'b0;
            end else if (c_win) begin
                own_c   <= 1'b1;
                h_op    <= 1'b0;
                h_atom  <= 1'b0;
                h_wstrb <= 4'b0;
                h_addr  <= c_addr;
                h_wdata <= 32'b0;
                h_ctype <= c_type;
            end
            if (cmpl && !own_c && !h_op)
                rdata_q <= dc_rdata;
            if (state == DONE)
                squash <= 1'b0;
            else if (state == BUSY && flush && !own_c)
                squash <= 1'b1;
            if (!c_valid || c_win)
                starve <= 4'b0;
            else if (p_win && starve < LIMIT)
                starve <= starve + 4'd1;
        end
    end

    assign in_busy       = (state == BUSY);
    assign busy          = (state != IDLE);
    assign p_ready       = p_win;
    assign c_ready       = c_win;
    assign dc_rvalid     = in_busy && !own_c && !h_op;
    assign dc_wvalid     = in_busy && !own_c && h_op;
    assign dc_cacop_en   = in_busy && own_c;
    assign dc_op         = in_busy && h_op;
    assign dc_atom       = in_busy && !own_c && h_atom;
    assign dc_addr       = in_busy ? h_addr : 32'b0;
    assign dc_wstrb      = dc_wvalid ? h_wstrb : 4'b0;
    assign dc_wdata      = dc_wvalid ? h_wdata : 32'b0;
    assign dc_cacop_type = dc_cacop_en ? h_ctype : 2'b0;
    // A flush landing in the DONE cycle itself still kills the pulse.
    assign p_done        = (state == DONE) && !own_c && !squash && !flush;
    assign c_done        = (state == DONE) && own_c;
    assign p_rdata       = rdata_q;

endmodule

// File: doc/dcache_port_arbiter.md
DCACHE_PORT_ARBITER -- requirements
Module: dcache_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, consecutive lost-arbitration cycles after which the CACOP requester wins (range 1..15).
REQ-002 aclk  in  1  clock; all state updates on rising edge.
REQ-003 aresetn  in  1  reset, synchronous, active-low.
REQ-004 flush  in  1  pipeline flush; squashes pipeline requests, never CACOP.
REQ-005 p_valid  in  1  pipeline load/store request.
REQ-006 p_op  in  1  0 read, 1 write.
REQ-007 p_wstrb  in  4  write mask: 0001 byte, 0011 half, 1111 word.
REQ-008 p_addr / p_wdata  in  32 each  address / store data.
REQ-009 p_atom  in  1  atomic (LL/SC) access.
REQ-010 p_ready  out  1  pipeline request accepted this cycle.
REQ-011 p_done  out  1  pipeline access complete; one-cycle pulse.
REQ-012 p_rdata  out  32  load data, valid with p_done.
REQ-013 c_valid  in  1  CACOP data-cache request.
REQ-014 c_type  in  2  CACOP operation code.
REQ-015 c_addr  in  32  CACOP virtual address.
REQ-016 c_ready / c_done  out  1 each  CACOP accepted / complete (one-cycle pulses).
REQ-017 dc_rvalid / dc_wvalid  out  1 each  dcache read / write request.
REQ-018 dc_op  out  1; dc_wstrb  out  4; dc_addr  out  32; dc_wdata  out  32; dc_atom  out  1  dcache request fields.
REQ-019 dc_cacop_en  out  1; dc_cacop_type  out  2  dcache CACOP request.
REQ-020 dc_rready / dc_wready / dc_cacop_done  in  1 each  dcache completion strobes.
REQ-021 dc_rdata  in  32  dcache read data, valid with dc_rready.
REQ-022 busy  out  1  high in any state other than IDLE.

Function
REQ-023 FSM states SHALL be IDLE, BUSY, DONE.
REQ-024 IDLE: if a request wins, assert matching p_ready or c_ready combinationally that cycle, latch all fields into holding registers, record owner, go BUSY.
REQ-025 Arbitration: pipeline wins by default; CACOP wins when c_valid and starve counter == STARVE_LIMIT.
REQ-026 Starve counter (4 bit) SHALL increment, saturating at STARVE_LIMIT, each IDLE cycle where c_valid is high and pipeline wins; clear when CACOP granted or c_valid low.
REQ-027 flush high in IDLE SHALL suppress pipeline grant that cycle (p_ready=0); CACOP may still be granted.
REQ-028 BUSY: dc_* outputs SHALL be driven only from holding registers; exactly one of dc_rvalid, dc_wvalid, dc_cacop_en high, held until completion.
REQ-029 Completion: read on dc_rready, write on dc_wready, CACOP on dc_cacop_done; strobes for the non-owner type SHALL be ignored.
REQ-030 On completion, capture dc_rdata into p_rdata register, go DONE; dc request outputs low from DONE onward.
REQ-031 DONE: assert p_done or c_done for exactly one cycle, return IDLE; no acceptance in DONE (minimum one dead cycle between requests).
REQ-032 Latency: accept cycle N, dc request asserted N+1, completion cycle M, done pulse M+1.
REQ-033 flush while pipeline owns BUSY or DONE SHALL set a squash flag: access runs to completion, p_done suppressed; flag cleared on return to IDLE.
REQ-034 Completion in the same cycle as BUSY entry is impossible; completion strobes in IDLE/DONE SHALL be ignored.
REQ-035 dc_wdata and dc_wstrb SHALL be zero for reads and CACOP.

Reset
REQ-036 aresetn low SHALL, at next edge, force IDLE, clear holding registers, starve counter, squash flag, p_rdata; all outputs 0.
REQ-037 Reset mid-BUSY SHALL abandon the in-flight access with no done pulse.

Verification
REQ-038 Read: p_valid, p_op=0, addr 0x1C000100; dc_rready with rdata 0xDEADBEEF 3 cycles later -> p_ready N, dc_rvalid N+1..N+3, p_done + p_rdata=0xDEADBEEF at N+4.
REQ-039 Write: p_op=1, wstrb=0011, wdata 0x0000ABCD -> dc_wvalid held until dc_wready, dc_wstrb=0011, p_done next cycle.
REQ-040 Starvation: p_valid and c_valid held high, STARVE_LIMIT=4 -> four pipeline grants, fifth grant to CACOP, counter cleared.
REQ-041 Flush: flush during pipeline read BUSY -> dc_rvalid stays until dc_rready, no p_done; flush in IDLE with both valid -> CACOP granted.
REQ-042 Reset: aresetn low during CACOP BUSY -> next cycle IDLE, dc_cacop_en=0, no c_done, busy=0.
